// File: rtl/seg_display_scanner_if.sv
// Core-to-display bundle: four digit patterns plus enable in, multiplexed segment/anode drive out.
// The core side is master; the scanner is slave. There is no backpressure.
interface seg_display_scanner_if;
    logic       enable;
    logic [6:0] programcounter_sixteen;
    logic [6:0] programcounter_one;
    logic [6:0] data_sixteen;
    logic [6:0] data_one;
    logic [6:0] seg_out;
    logic [3:0] an_out;
    logic [1:0] digit_idx;
    logic       frame_start;

    modport master (
        output enable, programcounter_sixteen, programcounter_one, data_sixteen, data_one,
        input  seg_out, an_out, digit_idx, frame_start
    );

    modport slave (
        input  enable, programcounter_sixteen, programcounter_one, data_sixteen, data_one,
        output seg_out, an_out, digit_idx, frame_start
    );
endinterface

// File: rtl/seg_display_scanner.sv
// 4-digit 7-segment scanner. Patterns are snapshotted once per frame, and each slot starts blanked.
// Outputs lag the scan state by one registered cycle. There is no backpressure; enable=0 darkens the display.
module seg_display_scanner #(
    parameter int REFRESH_DIV    = 50000,
    parameter int BLANK_CYCLES   = 1000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                   clk_in,
    input  logic                   reset,
    seg_display_scanner_if.slave   bus
);
    localparam int             CW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0]  CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0]  CNT_BLANK = CW'(BLANK_CYCLES);
    localparam logic [6:0]     SEG_OFF   = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [3:0]     AN_OFF    = AN_ACTIVE_LOW ? 4'hF : 4'h0;

    if (REFRESH_DIV < 2 || BLANK_CYCLES >= REFRESH_DIV || BLANK_CYCLES < 0) begin : g_bad_params
        $error("seg_display_scanner: need REFRESH_DIV >= 2 and 0 <= BLANK_CYCLES < REFRESH_DIV");
    end

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [6:0]    shadow_q [4];
    logic [6:0]    shadow_d [4];
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;
    logic [1:0]    digit_idx_q, digit_idx_d;
    logic          frame_start_q, frame_start_d;
    logic          load;

    assign load = bus.enable && (cnt_q == '0) && (idx_q == '0);

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            shadow_q      <= '{default: '0};
            seg_q         <= SEG_OFF;
            an_q          <= AN_OFF;
            digit_idx_q   <= '0;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            shadow_q      <= shadow_d;
            seg_q         <= seg_d;
            an_q          <= an_d;
            digit_idx_q   <= digit_idx_d;
            frame_start_q <= frame_start_d;
        end
    end

    always_comb begin
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        if (!bus.enable) begin
            cnt_d = '0;
            idx_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        if (load) begin
            shadow_d = '{bus.programcounter_sixteen, bus.programcounter_one,
                         bus.data_sixteen, bus.data_one};
        end
    end

    // Decode from shadow_d so a zero-length blank still shows the fresh snapshot on the load cycle.
    always_comb begin
        seg_d         = SEG_OFF;
        an_d          = AN_OFF;
        digit_idx_d   = '0;
        frame_start_d = load;
        if (bus.enable) begin
            digit_idx_d = idx_q;
            if (cnt_q >= CNT_BLANK) begin
                an_d  = (4'b1000 >> idx_q) ^ AN_OFF;
                seg_d = shadow_d[idx_q] ^ SEG_OFF;
            end
        end
    end

    assign bus.seg_out     = seg_q;
    assign bus.an_out      = an_q;
    assign bus.digit_idx   = digit_idx_q;
    assign bus.frame_start = frame_start_q;
endmodule

// File: tb/tb_seg_display_scanner.sv
// Bench for seg_display_scanner: an active-low instance and an active-high instance share the stimulus.
// Both are compared each cycle against a phase-count reference model.
module tb_seg_display_scanner;
    localparam int RD = 8;
    localparam int BL = 2;
    localparam int FRAME = 4 * RD;

    logic clk_in  = 1'b0;
    logic clk_run = 1'b0;
    logic reset   = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    seg_display_scanner_if ifa ();
    seg_display_scanner_if ifb ();

    seg_display_scanner #(.REFRESH_DIV(RD), .BLANK_CYCLES(BL), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1))
        u_dut_lo (.clk_in(clk_in), .reset(reset), .bus(ifa));
    seg_display_scanner #(.REFRESH_DIV(RD), .BLANK_CYCLES(BL), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0))
        u_dut_hi (.clk_in(clk_in), .reset(reset), .bus(ifb));

    assign ifb.enable                 = ifa.enable;
    assign ifb.programcounter_sixteen = ifa.programcounter_sixteen;
    assign ifb.programcounter_one     = ifa.programcounter_one;
    assign ifb.data_sixteen           = ifa.data_sixteen;
    assign ifb.data_one               = ifa.data_one;

    always #5 if (clk_run) clk_in = ~clk_in;

    // Reference model: ph counts enabled cycles since the scan (re)started.
    int         ph = 0;
    logic [6:0] snap [4];
    logic [3:0] lit_an;
    logic [6:0] lit_seg;
    logic       lit_fs;
    logic [1:0] exp_di;

    task automatic model_step();
        int slot, k;
        lit_an = '0; lit_seg = '0; lit_fs = 1'b0; exp_di = '0;
        if (!ifa.enable) begin
            ph = 0;
        end else begin
            if (ph % FRAME == 0) begin
                snap[0] = ifa.programcounter_sixteen;
                snap[1] = ifa.programcounter_one;
                snap[2] = ifa.data_sixteen;
                snap[3] = ifa.data_one;
                lit_fs  = 1'b1;
            end
            slot   = (ph / RD) % 4;
            k      = ph % RD;
            exp_di = 2'(slot);
            if (k >= BL) begin
                lit_an  = 4'b1000 >> slot;
                lit_seg = snap[slot];
            end
            ph++;
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_inputs(input logic [6:0] a, input logic [6:0] b, input logic [6:0] c, input logic [6:0] d);
        ifa.programcounter_sixteen = a;
        ifa.programcounter_one     = b;
        ifa.data_sixteen           = c;
        ifa.data_one               = d;
    endtask

    task automatic test_reset();
        ifa.enable = 1'b0;
        set_inputs(7'h06, 7'h5B, 7'h4F, 7'h66);
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({ifa.an_out, ifa.seg_out, ifa.digit_idx, ifa.frame_start} !== {4'b1111, 7'h7F, 2'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_lo got an=%b seg=%h di=%0d fs=%b want an=1111 seg=7f di=0 fs=0",
                     ifa.an_out, ifa.seg_out, ifa.digit_idx, ifa.frame_start);
        end
        n_checks++;
        if ({ifb.an_out, ifb.seg_out, ifb.digit_idx, ifb.frame_start} !== {4'b0000, 7'h00, 2'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_hi got an=%b seg=%h di=%0d fs=%b want an=0000 seg=00 di=0 fs=0",
                     ifb.an_out, ifb.seg_out, ifb.digit_idx, ifb.frame_start);
        end
        clk_run = 1'b1;
        #12 reset = 1'b1;
        ph = 0;
    endtask

    task automatic test_scan_order();
        cycle();
        ifa.enable = 1'b1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            cycle();
            n_checks++;
            if ({ifa.an_out, ifa.seg_out, ifa.frame_start, ifa.digit_idx} !== {~lit_an, ~lit_seg, lit_fs, exp_di}) begin
                n_fail++;
                $display("FAIL scan_lo i=%0d got an=%b seg=%h fs=%b di=%0d want an=%b seg=%h fs=%b di=%0d", i,
                         ifa.an_out, ifa.seg_out, ifa.frame_start, ifa.digit_idx, ~lit_an, ~lit_seg, lit_fs, exp_di);
            end
            n_checks++;
            if ({ifb.an_out, ifb.seg_out, ifb.frame_start} !== {lit_an, lit_seg, lit_fs}) begin
                n_fail++;
                $display("FAIL scan_hi i=%0d got an=%b seg=%h fs=%b want an=%b seg=%h fs=%b", i,
                         ifb.an_out, ifb.seg_out, ifb.frame_start, lit_an, lit_seg, lit_fs);
            end
            if (i == 0 || i == FRAME) begin
                n_checks++;
                if (ifa.frame_start !== 1'b1) begin
                    n_fail++;
                    $display("FAIL frame_pulse i=%0d got %b want 1", i, ifa.frame_start);
                end
            end
            if (i == 1 || i == 9) begin
                n_checks++;
                if (ifa.an_out !== 4'b1111) begin
                    n_fail++;
                    $display("FAIL blank i=%0d got an=%b want 1111", i, ifa.an_out);
                end
            end
            if (i == 2) begin
                n_checks++;
                if ({ifa.an_out, ifa.seg_out, ifb.an_out, ifb.seg_out} !== {4'b0111, 7'h79, 4'b1000, 7'h06}) begin
                    n_fail++;
                    $display("FAIL slot0 got lo=%b/%h hi=%b/%h want lo=0111/79 hi=1000/06",
                             ifa.an_out, ifa.seg_out, ifb.an_out, ifb.seg_out);
                end
            end
            if (i == 10 || i == 18 || i == 26) begin
                n_checks++;
                if ({ifa.an_out, ifa.seg_out} !==
                    ((i == 10) ? {4'b1011, 7'h24} : (i == 18) ? {4'b1101, 7'h30} : {4'b1110, 7'h19})) begin
                    n_fail++;
                    $display("FAIL slot_order i=%0d got an=%b seg=%h", i, ifa.an_out, ifa.seg_out);
                end
            end
        end
    endtask

    task automatic test_coherence();
        for (int i = 0; i < 2 * FRAME; i++) begin
            cycle();
            n_checks++;
            if ({ifa.an_out, ifa.seg_out, ifa.frame_start, ifa.digit_idx} !== {~lit_an, ~lit_seg, lit_fs, exp_di}) begin
                n_fail++;
                $display("FAIL coherence_lo i=%0d got an=%b seg=%h want an=%b seg=%h", i,
                         ifa.an_out, ifa.seg_out, ~lit_an, ~lit_seg);
            end
            if (i == 5) ifa.data_one = 7'h3F;
            if (i == 26 || i == FRAME + 26) begin
                n_checks++;
                if (ifa.seg_out !== ((i == 26) ? 7'h19 : 7'h40)) begin
                    n_fail++;
                    $display("FAIL coherence_slot3 i=%0d got seg=%h want %h", i, ifa.seg_out,
                             (i == 26) ? 7'h19 : 7'h40);
                end
            end
        end
    endtask

    task automatic test_enable_gating();
        for (int i = 0; i < 20; i++) cycle();
        ifa.enable = 1'b0;
        cycle();
        n_checks++;
        if ({ifa.an_out, ifa.digit_idx, ifa.frame_start} !== {4'b1111, 2'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL gate_off got an=%b di=%0d fs=%b want an=1111 di=0 fs=0",
                     ifa.an_out, ifa.digit_idx, ifa.frame_start);
        end
        set_inputs(7'h7F, 7'h01, 7'h02, 7'h04);
        cycle();
        cycle();
        ifa.enable = 1'b1;
        for (int i = 0; i < FRAME + 4; i++) begin
            cycle();
            n_checks++;
            if ({ifa.an_out, ifa.seg_out, ifa.frame_start, ifa.digit_idx} !== {~lit_an, ~lit_seg, lit_fs, exp_di}) begin
                n_fail++;
                $display("FAIL gate_on_lo i=%0d got an=%b seg=%h fs=%b want an=%b seg=%h fs=%b", i,
                         ifa.an_out, ifa.seg_out, ifa.frame_start, ~lit_an, ~lit_seg, lit_fs);
            end
            if (i == 0 || i == 2) begin
                n_checks++;
                if ((i == 0 && ifa.frame_start !== 1'b1) || (i == 2 && {ifa.an_out, ifa.seg_out} !== {4'b0111, 7'h00})) begin
                    n_fail++;
                    $display("FAIL gate_restart i=%0d got fs=%b an=%b seg=%h", i,
                             ifa.frame_start, ifa.an_out, ifa.seg_out);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        while (ph % FRAME != 0) cycle();
        for (int i = 0; i < 20; i++) cycle();
        n_checks++;
        if (ifa.an_out !== 4'b1101) begin
            n_fail++;
            $display("FAIL areset_pre got an=%b want 1101", ifa.an_out);
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({ifa.an_out, ifa.seg_out, ifa.digit_idx, ifb.an_out} !== {4'b1111, 7'h7F, 2'd0, 4'b0000}) begin
            n_fail++;
            $display("FAIL areset_now got an=%b seg=%h di=%0d hi_an=%b want 1111/7f/0/0000",
                     ifa.an_out, ifa.seg_out, ifa.digit_idx, ifb.an_out);
        end
        @(negedge clk_in);
        @(negedge clk_in);
        reset = 1'b1;
        ph = 0;
        for (int i = 0; i < FRAME + 4; i++) begin
            cycle();
            n_checks++;
            if ({ifa.an_out, ifa.seg_out, ifa.frame_start, ifa.digit_idx} !== {~lit_an, ~lit_seg, lit_fs, exp_di}) begin
                n_fail++;
                $display("FAIL areset_resume i=%0d got an=%b seg=%h fs=%b want an=%b seg=%h fs=%b", i,
                         ifa.an_out, ifa.seg_out, ifa.frame_start, ~lit_an, ~lit_seg, lit_fs);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            cycle();
            n_checks++;
            if ({ifa.an_out, ifa.seg_out, ifa.frame_start, ifa.digit_idx} !== {~lit_an, ~lit_seg, lit_fs, exp_di}) begin
                n_fail++;
                $display("FAIL random_lo i=%0d got an=%b seg=%h fs=%b di=%0d want an=%b seg=%h fs=%b di=%0d", i,
                         ifa.an_out, ifa.seg_out, ifa.frame_start, ifa.digit_idx, ~lit_an, ~lit_seg, lit_fs, exp_di);
            end
            n_checks++;
            if ({ifb.an_out, ifb.seg_out, ifb.frame_start, ifb.digit_idx} !== {lit_an, lit_seg, lit_fs, exp_di}) begin
                n_fail++;
                $display("FAIL random_hi i=%0d got an=%b seg=%h want an=%b seg=%h", i,
                         ifb.an_out, ifb.seg_out, lit_an, lit_seg);
            end
            if ($urandom_range(0, 5) == 0) begin
                case ($urandom_range(0, 3))
                    0: ifa.programcounter_sixteen = 7'($urandom);
                    1: ifa.programcounter_one     = 7'($urandom);
                    2: ifa.data_sixteen           = 7'($urandom);
                    default: ifa.data_one         = 7'($urandom);
                endcase
            end
            if (ifa.enable && $urandom_range(0, 59) == 0) ifa.enable = 1'b0;
            else if (!ifa.enable && $urandom_range(0, 3) == 0) ifa.enable = 1'b1;
        end
    endtask

    initial begin
        test_reset();
        test_scan_order();
        test_coherence();
        test_enable_gating();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/seg_display_scanner.md
Name: seg_display_scanner

Overview:
- Downstream of the microprocessor core. Consumes its four 7-segment digit patterns (programcounter_sixteen/one, data_sixteen/one) and time-multiplexes them onto a shared 4-digit common-anode display.
- A per-digit prescaler drives the scan, with a blanking interval at each digit change to suppress ghosting.
- All four inputs are snapshotted at frame start, so each displayed frame is coherent even while the core updates.

Parameters:
- REFRESH_DIV, 50000, clk_in cycles per digit slot; must be >= 2.
- BLANK_CYCLES, 1000, cycles at the start of each slot with all digits off; must be < REFRESH_DIV.
- SEG_ACTIVE_LOW, 1, 1: seg_out bit 0 lights a segment; 0: bit 1 lights.
- AN_ACTIVE_LOW, 1, 1: an_out bit 0 enables a digit; 0: bit 1 enables.

Ports:
- clk_in  input  1  system clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- enable  input  1  1 = scan running; 0 = display dark.
- programcounter_sixteen  input  7  PC high-nibble pattern; bit=1 means segment on; bits {g,f,e,d,c,b,a}.
- programcounter_one  input  7  PC low-nibble pattern, same encoding.
- data_sixteen  input  7  data high-nibble pattern, same encoding.
- data_one  input  7  data low-nibble pattern, same encoding.
- seg_out  output  7  segment drive, polarity per SEG_ACTIVE_LOW.
- an_out  output  4  digit enables; an_out[3] = leftmost digit; polarity per AN_ACTIVE_LOW.
- digit_idx  output  2  slot index currently being scanned.
- frame_start  output  1  one-cycle pulse at each frame snapshot.

Behaviour:
- State:
  - cnt: width clog2(REFRESH_DIV), counts 0..REFRESH_DIV-1.
  - idx: 2 bits.
  - shadow[0..3]: 7 bits each.
  - All outputs are registered.
- Reset (reset=0, asynchronous, no clock needed):
  - cnt=0, idx=0, shadow=0, frame_start=0, digit_idx=0.
  - an_out and seg_out at their "off" level: an_out=4'b1111 and seg_out=7'h7F for the active-low defaults; 0 for active-high.
- Load event: cycle with enable=1 and cnt=0 and idx=0.
  - On that edge, shadow[0..3] <= {programcounter_sixteen, programcounter_one, data_sixteen, data_one}.
  - frame_start is 1 for the following cycle only.
- Slot counting (enable=1):
  - cnt increments each cycle.
  - At cnt=REFRESH_DIV-1: cnt<=0 and idx<=idx+1, wrapping 3->0.
  - The wrap to cnt=0, idx=0 produces the next load event.
- Output decode, registered; values in cycle N+1 reflect state in cycle N:
  - cnt < BLANK_CYCLES: all digits off, segments off.
  - Otherwise: enable only the digit mapped from idx and drive seg_out = shadow[idx], applying polarity.
  - Mapping: idx0 -> an_out[3], idx1 -> an_out[2], idx2 -> an_out[1], idx3 -> an_out[0].
- digit_idx is a registered copy of idx, aligned with an_out.
- Frame period is 4*REFRESH_DIV cycles.
- Input changes mid-frame never reach the outputs before the next load event.
- enable=0:
  - cnt and idx cleared to 0 on the next edge; shadow holds.
  - Outputs off from the following cycle; frame_start=0.
- enable 0->1: the first enabled cycle is a load event, so the scan restarts at idx0 with a fresh snapshot.
- Simultaneous load event and input change: the value present at that edge is captured.
- Reset asserted mid-slot: immediate return to reset values. After release, operation resumes as from power-up; the first enabled cycle is a load event.
- Parameter violations (BLANK_CYCLES >= REFRESH_DIV, or REFRESH_DIV < 2) are rejected at elaboration.

Test Plan:
- Common bench parameters: REFRESH_DIV=8, BLANK_CYCLES=2.
- Reset: reset=0 with clock stopped -> an_out=4'b1111, seg_out=7'h7F, digit_idx=0, frame_start=0.
- Scan order: inputs 7'h06, 7'h5B, 7'h4F, 7'h66, enable=1 ->
  - frame_start pulse, then per 8-cycle slot: 2 cycles an_out=4'b1111.
  - Then 6 cycles of each in turn: an_out=4'b0111/seg_out=7'h79, then 4'b1011/7'h24, 4'b1101/7'h30, 4'b1110/7'h19.
  - frame_start repeats every 32 cycles.
- Coherence: change data_one from 7'h66 to 7'h3F at cycle 5 of a frame -> slot 3 still shows seg_out=7'h19; the next frame shows 7'h40.
- Enable gating: drop enable in slot 2 at cnt=4 -> next cycle an_out=4'b1111, idx=0. Raise enable -> frame_start pulse and slot 0 restarts with a fresh snapshot.
- Async reset mid-slot: assert reset=0 between clock edges while an_out=4'b1101 -> an_out=4'b1111 immediately, digit_idx=0.
- Polarity: SEG_ACTIVE_LOW=0, AN_ACTIVE_LOW=0, input 7'h06 -> blank gives an_out=0/seg_out=0; active gives an_out=4'b1000/seg_out=7'h06.
